ibex_fetch_lsu_arbiter: RTL and testbench

- Shares one OBI-style memory port between the instruction fetch path (prefetch buffer side) and the load/store unit of the core.
- Picks one requester per bus transaction and holds that choice stable until the bus grants it.
- Records the owner of every outstanding transaction in an in-order tag FIFO and routes each response back to its owner.
- Sits between the fetch/LSU bus masters and the single core-level memory interface.

---
 rtl/ibex_fetch_lsu_arbiter.sv | 209 ++++++++++++++++++++
 tb/tb_ibex_fetch_lsu_arbiter.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ibex_fetch_lsu_arbiter.sv
// Shares one OBI memory port between instruction fetch and the LSU; an in-order owner FIFO steers responses back.
// Optional build macro: IBEX_ARB_ROUND_ROBIN_EN (round-robin tie breaking instead of fixed DataPriority).
module ibex_fetch_lsu_arbiter #(
  parameter int unsigned MaxOutstanding = 2,
  parameter bit          DataPriority   = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_ni,

  input  logic        instr_req_i,
  input  logic [31:0] instr_addr_i,
  output logic        instr_gnt_o,
  output logic        instr_rvalid_o,
  output logic [31:0] instr_rdata_o,
  output logic        instr_err_o,

  input  logic        data_req_i,
  input  logic [31:0] data_addr_i,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_wdata_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  output logic [31:0] data_rdata_o,
  output logic        data_err_o,

  output logic        bus_req_o,
  output logic [31:0] bus_addr_o,
  output logic        bus_we_o,
  output logic [3:0]  bus_be_o,
  output logic [31:0] bus_wdata_o,
  input  logic        bus_gnt_i,
  input  logic        bus_rvalid_i,
  input  logic [31:0] bus_rdata_i,
  input  logic        bus_err_i,

  output logic        busy_o,
  output logic        resp_unexp_o
);

  localparam int unsigned CntW = $clog2(MaxOutstanding + 1);
  localparam int unsigned PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
  localparam logic [CntW-1:0] MaxCnt  = CntW'(MaxOutstanding);
  localparam logic [PtrW-1:0] LastIdx = PtrW'(MaxOutstanding - 1);

  typedef enum logic {
    OwnFetch = 1'b0,
    OwnData  = 1'b1
  } owner_e;

  logic            lock_q, lock_d;
  owner_e          owner_q, owner_d;
  logic [CntW-1:0] count_q, count_d;
  logic [PtrW-1:0] wptr_q, wptr_d;
  logic [PtrW-1:0] rptr_q, rptr_d;
  owner_e          tagFifo_q [MaxOutstanding];
  logic            respUnexp_q, respUnexp_d;

  owner_e winner;
  owner_e tieWinner;
  logic   winnerValid;
  owner_e sel;
  logic   selValid;
  logic   slotFree;
  logic   grant;
  logic   pop;
  owner_e headTag;

`ifdef IBEX_ARB_ROUND_ROBIN_EN
  // Pointer holds the requester that should win the next tie: the one not granted last.
  owner_e rrPtr_q, rrPtr_d;

  always_comb begin
    rrPtr_d = rrPtr_q;
    if (grant) begin
      rrPtr_d = (sel == OwnFetch) ? OwnData : OwnFetch;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rrPtr_q <= OwnFetch;
    end else begin
      rrPtr_q <= rrPtr_d;
    end
  end

  assign tieWinner = rrPtr_q;
`else
  assign tieWinner = DataPriority ? OwnData : OwnFetch;
`endif

  always_comb begin
    winnerValid = instr_req_i | data_req_i;
    winner      = OwnFetch;
    if (instr_req_i && data_req_i) begin
      winner = tieWinner;
    end else if (data_req_i) begin
      winner = OwnData;
    end
  end

  // A held lock overrides fresh arbitration so the bus sees stable fields until granted.
  assign sel      = lock_q ? owner_q : winner;
  assign selValid = lock_q | winnerValid;

  // A response in the same cycle frees a slot, so a full FIFO may still accept a new request.
  assign pop      = bus_rvalid_i & (count_q != '0);
  assign slotFree = (count_q != MaxCnt) | pop;

  assign bus_req_o   = selValid & slotFree;
  assign grant       = bus_req_o & bus_gnt_i;
  assign instr_gnt_o = grant & (sel == OwnFetch);
  assign data_gnt_o  = grant & (sel == OwnData);

  always_comb begin
    bus_addr_o  = '0;
    bus_we_o    = 1'b0;
    bus_be_o    = '0;
    bus_wdata_o = '0;
    if (selValid) begin
      if (sel == OwnData) begin
        bus_addr_o  = data_addr_i;
        bus_we_o    = data_we_i;
        bus_be_o    = data_be_i;
        bus_wdata_o = data_wdata_i;
      end else begin
        bus_addr_o  = instr_addr_i;
        bus_be_o    = 4'hF;
      end
    end
  end

  always_comb begin
    lock_d  = lock_q;
    owner_d = owner_q;
    if (lock_q) begin
      if (grant) begin
        lock_d = 1'b0;
      end
    end else if (bus_req_o && !bus_gnt_i) begin
      lock_d  = 1'b1;
      owner_d = winner;
    end
  end

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (grant) begin
      wptr_d = (wptr_q == LastIdx) ? '0 : wptr_q + PtrW'(1);
    end
    if (pop) begin
      rptr_d = (rptr_q == LastIdx) ? '0 : rptr_q + PtrW'(1);
    end
    if (grant && !pop) begin
      count_d = count_q + CntW'(1);
    end else if (pop && !grant) begin
      count_d = count_q - CntW'(1);
    end
  end

  assign respUnexp_d = respUnexp_q | (bus_rvalid_i & (count_q == '0));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lock_q      <= 1'b0;
      owner_q     <= OwnFetch;
      count_q     <= '0;
      wptr_q      <= '0;
      rptr_q      <= '0;
      respUnexp_q <= 1'b0;
    end else begin
      lock_q      <= lock_d;
      owner_q     <= owner_d;
      count_q     <= count_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      respUnexp_q <= respUnexp_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < MaxOutstanding; i++) begin
        tagFifo_q[i] <= OwnFetch;
      end
    end else if (grant) begin
      tagFifo_q[wptr_q] <= sel;
    end
  end

  // Read data and error fan out to both masters; only the valid strobes are steered.
  assign headTag        = tagFifo_q[rptr_q];
  assign instr_rvalid_o = pop & (headTag == OwnFetch);
  assign data_rvalid_o  = pop & (headTag == OwnData);
  assign instr_rdata_o  = bus_rdata_i;
  assign data_rdata_o   = bus_rdata_i;
  assign instr_err_o    = bus_err_i;
  assign data_err_o     = bus_err_i;

  assign busy_o       = (count_q != '0) | lock_q;
  assign resp_unexp_o = respUnexp_q;

  assert property (@(posedge clk_i) disable iff (!rst_ni) !(instr_gnt_o && data_gnt_o));
  assert property (@(posedge clk_i) disable iff (!rst_ni) count_q <= MaxCnt);

endmodule

// File: tb/tb_ibex_fetch_lsu_arbiter.sv
// Self-checking bench for ibex_fetch_lsu_arbiter: per-cycle vector table plus an owner scoreboard for responses.
module tb_ibex_fetch_lsu_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        instr_req_i;
  logic [31:0] instr_addr_i;
  logic        instr_gnt_o, instr_rvalid_o, instr_err_o;
  logic [31:0] instr_rdata_o;
  logic        data_req_i, data_we_i;
  logic [31:0] data_addr_i, data_wdata_i;
  logic [3:0]  data_be_i;
  logic        data_gnt_o, data_rvalid_o, data_err_o;
  logic [31:0] data_rdata_o;
  logic        bus_req_o, bus_we_o;
  logic [31:0] bus_addr_o, bus_wdata_o;
  logic [3:0]  bus_be_o;
  logic        bus_gnt_i, bus_rvalid_i, bus_err_i;
  logic [31:0] bus_rdata_i;
  logic        busy_o, resp_unexp_o;

  always #5 clk_i = ~clk_i;

  ibex_fetch_lsu_arbiter #(
    .MaxOutstanding(2),
    .DataPriority  (1'b1)
  ) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .instr_req_i   (instr_req_i),
    .instr_addr_i  (instr_addr_i),
    .instr_gnt_o   (instr_gnt_o),
    .instr_rvalid_o(instr_rvalid_o),
    .instr_rdata_o (instr_rdata_o),
    .instr_err_o   (instr_err_o),
    .data_req_i    (data_req_i),
    .data_addr_i   (data_addr_i),
    .data_we_i     (data_we_i),
    .data_be_i     (data_be_i),
    .data_wdata_i  (data_wdata_i),
    .data_gnt_o    (data_gnt_o),
    .data_rvalid_o (data_rvalid_o),
    .data_rdata_o  (data_rdata_o),
    .data_err_o    (data_err_o),
    .bus_req_o     (bus_req_o),
    .bus_addr_o    (bus_addr_o),
    .bus_we_o      (bus_we_o),
    .bus_be_o      (bus_be_o),
    .bus_wdata_o   (bus_wdata_o),
    .bus_gnt_i     (bus_gnt_i),
    .bus_rvalid_i  (bus_rvalid_i),
    .bus_rdata_i   (bus_rdata_i),
    .bus_err_i     (bus_err_i),
    .busy_o        (busy_o),
    .resp_unexp_o  (resp_unexp_o)
  );

  typedef struct {
    string       name;
    logic        iReq;
    logic [31:0] iAddr;
    logic        dReq;
    logic [31:0] dAddr;
    logic        dWe;
    logic [3:0]  dBe;
    logic [31:0] dWdata;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        err;
    logic        eReq;
    logic [31:0] eAddr;
    logic        eWe;
    logic [3:0]  eBe;
    logic [31:0] eWdata;
    logic        eIGnt;
    logic        eDGnt;
    logic        eBusy;
  } vec_t;

  vec_t tableA[$];
  vec_t tableB[$];
  logic sbOwner[$];
  logic expUnexp;
  logic rr;
  int   checks;
  int   failures;

  function automatic vec_t mk(input string name,
                              input logic iReq, input logic [31:0] iAddr,
                              input logic dReq, input logic [31:0] dAddr, input logic dWe,
                              input logic [3:0] dBe, input logic [31:0] dWdata,
                              input logic gnt, input logic rvalid, input logic [31:0] rdata, input logic err,
                              input logic eReq, input logic [31:0] eAddr, input logic eWe,
                              input logic [3:0] eBe, input logic [31:0] eWdata,
                              input logic eIGnt, input logic eDGnt, input logic eBusy);
    vec_t v;
    v.name = name;   v.iReq = iReq;   v.iAddr = iAddr;
    v.dReq = dReq;   v.dAddr = dAddr; v.dWe = dWe; v.dBe = dBe; v.dWdata = dWdata;
    v.gnt = gnt;     v.rvalid = rvalid; v.rdata = rdata; v.err = err;
    v.eReq = eReq;   v.eAddr = eAddr; v.eWe = eWe; v.eBe = eBe; v.eWdata = eWdata;
    v.eIGnt = eIGnt; v.eDGnt = eDGnt; v.eBusy = eBusy;
    return v;
  endfunction

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  task automatic driveIdle();
    instr_req_i = 1'b0; instr_addr_i = '0;
    data_req_i = 1'b0; data_addr_i = '0; data_we_i = 1'b0; data_be_i = '0; data_wdata_i = '0;
    bus_gnt_i = 1'b0; bus_rvalid_i = 1'b0; bus_rdata_i = '0; bus_err_i = 1'b0;
  endtask

  task automatic applyStimulus(input vec_t v);
    @(posedge clk_i);
    #1;
    instr_req_i = v.iReq; instr_addr_i = v.iAddr;
    data_req_i = v.dReq; data_addr_i = v.dAddr; data_we_i = v.dWe; data_be_i = v.dBe;
    data_wdata_i = v.dWdata;
    bus_gnt_i = v.gnt; bus_rvalid_i = v.rvalid; bus_rdata_i = v.rdata; bus_err_i = v.err;
  endtask

  // Responses are checked against the oldest expected owner before this cycle's grant is queued.
  task automatic checkOutput(input vec_t v);
    logic owner;
    logic emptyResp;
    @(negedge clk_i);
    cmp({v.name, ".bus_req"},   bus_req_o,   v.eReq);
    cmp({v.name, ".bus_addr"},  bus_addr_o,  v.eAddr);
    cmp({v.name, ".bus_we"},    bus_we_o,    v.eWe);
    cmp({v.name, ".bus_be"},    bus_be_o,    v.eBe);
    cmp({v.name, ".bus_wdata"}, bus_wdata_o, v.eWdata);
    cmp({v.name, ".instr_gnt"}, instr_gnt_o, v.eIGnt);
    cmp({v.name, ".data_gnt"},  data_gnt_o,  v.eDGnt);
    cmp({v.name, ".busy"},      busy_o,      v.eBusy);
    emptyResp = v.rvalid && (sbOwner.size() == 0);
    if (v.rvalid && !emptyResp) begin
      owner = sbOwner.pop_front();
      cmp({v.name, ".instr_rvalid"}, instr_rvalid_o, !owner);
      cmp({v.name, ".data_rvalid"},  data_rvalid_o,  owner);
      cmp({v.name, ".instr_rdata"},  instr_rdata_o,  v.rdata);
      cmp({v.name, ".data_rdata"},   data_rdata_o,   v.rdata);
      cmp({v.name, ".instr_err"},    instr_err_o,    v.err);
      cmp({v.name, ".data_err"},     data_err_o,     v.err);
    end else begin
      cmp({v.name, ".instr_rvalid"}, instr_rvalid_o, 1'b0);
      cmp({v.name, ".data_rvalid"},  data_rvalid_o,  1'b0);
    end
    cmp({v.name, ".resp_unexp"}, resp_unexp_o, expUnexp);
    if (emptyResp) expUnexp = 1'b1;
    if (v.eIGnt) sbOwner.push_back(1'b0);
    if (v.eDGnt) sbOwner.push_back(1'b1);
  endtask

  task automatic checkReset(input string name);
    cmp({name, ".bus_req"},      bus_req_o,      1'b0);
    cmp({name, ".bus_addr"},     bus_addr_o,     32'h0);
    cmp({name, ".bus_be"},       bus_be_o,       4'h0);
    cmp({name, ".bus_we"},       bus_we_o,       1'b0);
    cmp({name, ".bus_wdata"},    bus_wdata_o,    32'h0);
    cmp({name, ".instr_gnt"},    instr_gnt_o,    1'b0);
    cmp({name, ".data_gnt"},     data_gnt_o,     1'b0);
    cmp({name, ".instr_rvalid"}, instr_rvalid_o, 1'b0);
    cmp({name, ".data_rvalid"},  data_rvalid_o,  1'b0);
    cmp({name, ".busy"},         busy_o,         1'b0);
    cmp({name, ".resp_unexp"},   resp_unexp_o,   1'b0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    checks = 0;
    failures = 0;
    expUnexp = 1'b0;
`ifdef IBEX_ARB_ROUND_ROBIN_EN
    rr = 1'b1;
`else
    rr = 1'b0;
`endif

    // name, iReq,iAddr, dReq,dAddr,dWe,dBe,dWdata, gnt,rvalid,rdata,err, eReq,eAddr,eWe,eBe,eWdata, eIGnt,eDGnt,eBusy
    tableA.push_back(mk("fetchGnt",    1, 32'h80,  0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 32'h80, 0, 4'hF, 0, 1, 0, 0));
    tableA.push_back(mk("fetchWait",   0, 0,       0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    tableA.push_back(mk("fetchResp",   0, 0,       0, 0, 0, 0, 0, 0, 1, 32'h13, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    tableA.push_back(mk("idle0",       0, 0,       0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tableA.push_back(mk("tieData",     1, 32'h200, 1, 32'h1000, 1, 4'h3, 32'hA5A5, 1, 0, 0, 0,
                        1, 32'h1000, 1, 4'h3, 32'hA5A5, 0, 1, 0));
    tableA.push_back(mk("tieSecond",   1, 32'h200, 1, 32'h1004, 0, 4'hF, 0, 1, 0, 0, 0,
                        1, rr ? 32'h200 : 32'h1004, 0, 4'hF, 0, rr, !rr, 1));
    tableA.push_back(mk("pushPopFull", !rr, 32'h200, rr, 32'h1004, 0, 4'hF, 0, 1, 1, 32'h33, 0,
                        1, rr ? 32'h1004 : 32'h200, 0, 4'hF, 0, !rr, rr, 1));
    tableA.push_back(mk("fullBlock",   1, 32'h300, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 32'h300, 0, 4'hF, 0, 0, 0, 1));
    tableA.push_back(mk("lockSet",     1, 32'h300, 0, 0, 0, 0, 0, 0, 1, 32'h44, 0, 1, 32'h300, 0, 4'hF, 0, 0, 0, 1));
    tableA.push_back(mk("lockHold1",   1, 32'h300, 1, 32'h2000, 1, 4'h3, 32'hDEAD, 0, 0, 0, 0,
                        1, 32'h300, 0, 4'hF, 0, 0, 0, 1));
    tableA.push_back(mk("lockHold2",   1, 32'h300, 1, 32'h2000, 1, 4'h3, 32'hDEAD, 0, 0, 0, 0,
                        1, 32'h300, 0, 4'hF, 0, 0, 0, 1));
    tableA.push_back(mk("lockGnt",     1, 32'h300, 1, 32'h2000, 1, 4'h3, 32'hDEAD, 1, 0, 0, 0,
                        1, 32'h300, 0, 4'hF, 0, 1, 0, 1));
    tableA.push_back(mk("dataFull",    0, 0, 1, 32'h2000, 1, 4'h3, 32'hDEAD, 1, 0, 0, 0,
                        0, 32'h2000, 1, 4'h3, 32'hDEAD, 0, 0, 1));
    tableA.push_back(mk("dataPushPop", 0, 0, 1, 32'h2000, 1, 4'h3, 32'hDEAD, 1, 1, 32'h55, 0,
                        1, 32'h2000, 1, 4'h3, 32'hDEAD, 0, 1, 1));
    tableA.push_back(mk("respFetch",   0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h66, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    tableA.push_back(mk("respDataErr", 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h77, 1, 0, 0, 0, 0, 0, 0, 0, 1));
    tableA.push_back(mk("idle1",       0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tableA.push_back(mk("unexpResp",   0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h88, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tableA.push_back(mk("unexpHold1",  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tableA.push_back(mk("unexpHold2",  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    tableB.push_back(mk("fill1",       1, 32'h400, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 32'h400, 0, 4'hF, 0, 1, 0, 0));
    tableB.push_back(mk("fill2",       0, 0, 1, 32'h404, 1, 4'hC, 32'h1234, 1, 0, 0, 0,
                        1, 32'h404, 1, 4'hC, 32'h1234, 0, 1, 1));
    tableB.push_back(mk("fill3Block",  1, 32'h408, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 32'h408, 0, 4'hF, 0, 0, 0, 1));

    rst_ni = 1'b0;
    driveIdle();
    repeat (3) @(negedge clk_i);
    checkReset("reset");
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;

    foreach (tableA[i]) begin
      applyStimulus(tableA[i]);
      checkOutput(tableA[i]);
    end

    foreach (tableB[i]) begin
      applyStimulus(tableB[i]);
      checkOutput(tableB[i]);
    end
    cmp("fill.count", 32'(dut.count_q), 32'd2);

    // Mid-transaction reset discards tracking and clears the sticky flag.
    @(posedge clk_i);
    #1;
    driveIdle();
    rst_ni = 1'b0;
    @(negedge clk_i);
    checkReset("midReset");
    sbOwner.delete();
    expUnexp = 1'b0;
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;

    applyStimulus(mk("lateResp",  0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h99, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    checkOutput(mk("lateResp",    0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h99, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    applyStimulus(mk("lateHold",  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    checkOutput(mk("lateHold",    0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
